fml_txn_capture: RTL
====================

Name: fml_txn_capture

Overview:
Parametrised transaction-capture block for the formal and verification abstraction layer of the CPU/COP interface. It tracks up to MAX_OUT in-flight COP instructions, each with a pre-issue CPR snapshot. It records a history of completed memory transactions and attributes their count to the oldest in-flight instruction. On each retirement it emits one-cycle retire records for checker modules. It replaces the fixed single-outstanding, fixed-depth capture logic in the formal top level.

Parameters:
XLEN, 32, data width of rs1/rs2/wdata/memory data
NCPR, 16, number of snooped CPRs
MAX_OUT, 2, in-flight instruction queue depth (power of 2, >=1)
MEM_DEPTH, 5, completed memory transactions held in history (>=1)
CNTW, 4, width of per-instruction memory transaction counter

Ports:
g_clk  in  1  clock
g_resetn  in  1  synchronous active-low reset
cpu_insn_req/cop_insn_ack  in  1/1  issue handshake
cpu_insn_enc  in  32  instruction encoding
cpu_rs1/cpu_rs2  in  XLEN  source operands
cop_insn_rsp/cpu_insn_ack  in  1/1  retire handshake
cop_result  in  3  result code
cop_wen/cop_waddr/cop_wdata  in  1/5/XLEN  GPR writeback
cprs_snoop  in  NCPR*XLEN  flat CPR snoop, CPR i at [i*XLEN+:XLEN]
cop_mem_cen/wen/stall/error  in  1 each  memory control
cop_mem_addr/wdata/rdata  in  32/XLEN/XLEN  memory address and data
cop_mem_ben  in  4  byte enables
cop_random/cop_rand_sample  in  XLEN/1  random sample interface
vtx_valid  out  1  retire record valid (single-cycle pulse)
vtx_enc/vtx_rs1/vtx_rs2  out  32/XLEN/XLEN  retired instruction
vtx_result/vtx_wen/vtx_waddr/vtx_wdata  out  3/1/5/XLEN  retired response
vtx_cprs_pre/vtx_cprs_post  out  NCPR*XLEN  CPR snapshots at issue and at retire
vtx_mem_count  out  CNTW  memory transactions completed while this instruction was head
vtx_mem_hist  out  MEM_DEPTH*(2+32+2*XLEN+4)  history; entry 0 newest; fields {err,wen,addr,wdata,rdata,ben}
vtx_mem_hvalid  out  MEM_DEPTH  per-entry valid
vtx_outstanding  out  clog2(MAX_OUT+1)  queue occupancy
vtx_proto_err  out  1  sticky protocol-violation flag
vtx_rand  out  XLEN  random sample latched at retire

Behaviour:
- Reset: g_resetn synchronous active-low; clock g_clk. On reset, every output is 0, the queue is empty, the history valids are cleared, the pending memory request is cleared and the counter is 0. Reset mid-operation discards all in-flight state.
- Issue: when cpu_insn_req&&cop_insn_ack, push {enc,rs1,rs2,cprs_snoop} at the queue tail.
- Retire: when cop_insn_rsp&&cpu_insn_ack, pop the head. On the next cycle:
  - vtx_valid=1 for exactly one cycle.
  - vtx_* carry the head fields, the cop_* response and cprs_snoop sampled in the retire cycle.
  - Between retirements the vtx_* record fields hold their values.
- Simultaneous issue and retire with a non-empty queue: pop the old head, push the new entry, occupancy unchanged.
- Empty queue:
  - Issue and retire in the same cycle: push only, no retire record, and set vtx_proto_err.
  - Retire alone: ignored, and set vtx_proto_err.
- Full queue: issue is not pushed; set vtx_proto_err.
- Held request: if cpu_insn_req=1 with cop_insn_ack=0 and enc/rs1/rs2 change next cycle, set vtx_proto_err.
- vtx_proto_err clears only on reset.
- Memory request acceptance: cop_mem_cen=1 and (no pending request, or the pending request completes this cycle). Latch {wen,addr,wdata,ben}.
- Memory completion: pending request and cop_mem_stall=0. Sample rdata and error, then shift the history so the new record becomes entry 0 and the oldest entry falls off at MEM_DEPTH-1.
- cop_mem_error while nothing is pending sets vtx_proto_err.
- Memory counter:
  - Increments, saturating at 2^CNTW-1, on each completion while the queue is non-empty.
  - Latched into vtx_mem_count and reset to 0 at retire.
  - A completion in the retire cycle counts toward the retiring instruction.

Optional Feature:
FML_RAND_TRACK_EN:
- Defined: a sample register loads cop_random when cop_rand_sample=1, and is zero on reset. vtx_rand takes this register's value at each retire; a sample arriving in the retire cycle is included.
- Undefined: cop_random and cop_rand_sample are ignored and vtx_rand is tied to 0.

Test Plan:
1. Reset held 3 cycles, then released with no traffic -> all outputs 0, vtx_outstanding=0.
2. Issue enc=0x0000_702B, rs1=0x11, rs2=0x22; retire 4 cycles later with result=0, wen=1, waddr=5, wdata=0xABCD -> single vtx_valid pulse carrying those values; cprs_pre equals the snoop at issue, cprs_post equals the snoop at retire.
3. MAX_OUT=2: issue A, issue B, then issue C while full -> C dropped, vtx_proto_err=1. Retire twice -> records A then B in order.
4. Instruction head while 3 memory transactions complete (one stalled 2 cycles) with addrs 0x100/0x104/0x108 -> vtx_mem_count=3; vtx_mem_hist entry 0 addr=0x108, entry 2 addr=0x100; hvalid=3'b111.
5. Retire asserted with an empty queue -> no vtx_valid, vtx_proto_err=1, remains set until reset.
6. With FML_RAND_TRACK_EN, sample 0xDEADBEEF, then retire -> vtx_rand=0xDEADBEEF. Without the macro -> vtx_rand=0.

Source files
------------

// File: rtl/fml_txn_capture.sv
// Transaction capture for the CPU/COP formal layer. It tracks in-flight COP instructions,
// keeps a memory history and emits one-cycle retire records. Optional macro: FML_RAND_TRACK_EN.
module fml_txn_capture #(
    parameter int XLEN      = 32,
    parameter int NCPR      = 16,
    parameter int MAX_OUT   = 2,
    parameter int MEM_DEPTH = 5,
    parameter int CNTW      = 4
) (
    input  logic                                  g_clk,
    input  logic                                  g_resetn,
    input  logic                                  cpu_insn_req,
    input  logic                                  cop_insn_ack,
    input  logic [31:0]                           cpu_insn_enc,
    input  logic [XLEN-1:0]                       cpu_rs1,
    input  logic [XLEN-1:0]                       cpu_rs2,
    input  logic                                  cop_insn_rsp,
    input  logic                                  cpu_insn_ack,
    input  logic [2:0]                            cop_result,
    input  logic                                  cop_wen,
    input  logic [4:0]                            cop_waddr,
    input  logic [XLEN-1:0]                       cop_wdata,
    input  logic [NCPR*XLEN-1:0]                  cprs_snoop,
    input  logic                                  cop_mem_cen,
    input  logic                                  cop_mem_wen,
    input  logic                                  cop_mem_stall,
    input  logic                                  cop_mem_error,
    input  logic [31:0]                           cop_mem_addr,
    input  logic [XLEN-1:0]                       cop_mem_wdata,
    input  logic [XLEN-1:0]                       cop_mem_rdata,
    input  logic [3:0]                            cop_mem_ben,
    input  logic [XLEN-1:0]                       cop_random,
    input  logic                                  cop_rand_sample,
    output logic                                  vtx_valid,
    output logic [31:0]                           vtx_enc,
    output logic [XLEN-1:0]                       vtx_rs1,
    output logic [XLEN-1:0]                       vtx_rs2,
    output logic [2:0]                            vtx_result,
    output logic                                  vtx_wen,
    output logic [4:0]                            vtx_waddr,
    output logic [XLEN-1:0]                       vtx_wdata,
    output logic [NCPR*XLEN-1:0]                  vtx_cprs_pre,
    output logic [NCPR*XLEN-1:0]                  vtx_cprs_post,
    output logic [CNTW-1:0]                       vtx_mem_count,
    output logic [MEM_DEPTH*(2+32+2*XLEN+4)-1:0]  vtx_mem_hist,
    output logic [MEM_DEPTH-1:0]                  vtx_mem_hvalid,
    output logic [$clog2(MAX_OUT+1)-1:0]          vtx_outstanding,
    output logic                                  vtx_proto_err,
    output logic [XLEN-1:0]                       vtx_rand
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int HW = 2 + 32 + 2 * XLEN + 4;
    localparam int CW = NCPR * XLEN;

    localparam logic [OW-1:0]   FULL_CNT = OW'(MAX_OUT);
    localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_OUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // in-flight instruction storage
    logic [31:0]     r_q_enc  [MAX_OUT];
    logic [XLEN-1:0] r_q_rs1  [MAX_OUT];
    logic [XLEN-1:0] r_q_rs2  [MAX_OUT];
    logic [CW-1:0]   r_q_cprs [MAX_OUT];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [OW-1:0]   r_count;

    logic            r_proto_err;
    logic            r_held;
    logic [31:0]     r_held_enc;
    logic [XLEN-1:0] r_held_rs1;
    logic [XLEN-1:0] r_held_rs2;

    logic            r_mpend;
    logic            r_m_wen;
    logic [31:0]     r_m_addr;
    logic [XLEN-1:0] r_m_wdata;
    logic [3:0]      r_m_ben;
    logic [CNTW-1:0] r_cnt;

    logic            w_issue;
    logic            w_retire;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_mcomp;
    logic            w_macc;
    logic            w_held_chg;
    logic            w_proto_set;
    logic            w_cnt_bump;
    logic [CNTW-1:0] w_cnt_cur;
    logic [HW-1:0]   w_hist_new;

    assign w_issue  = cpu_insn_req & cop_insn_ack;
    assign w_retire = cop_insn_rsp & cpu_insn_ack;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = w_retire & ~w_empty;
    // A retire in the same cycle frees the slot, so a full queue can still accept.
    assign w_push   = w_issue & (~w_full | w_pop);

    assign w_mcomp  = r_mpend & ~cop_mem_stall;
    assign w_macc   = cop_mem_cen & (~r_mpend | w_mcomp);

    assign w_held_chg = r_held & ((cpu_insn_enc != r_held_enc) |
                                  (cpu_rs1 != r_held_rs1) |
                                  (cpu_rs2 != r_held_rs2));

    assign w_proto_set = (w_retire & w_empty) |
                         (w_issue & w_full & ~w_pop) |
                         w_held_chg |
                         (cop_mem_error & ~r_mpend);

    // Completion in the retire cycle is credited to the retiring head.
    assign w_cnt_bump = w_mcomp & ~w_empty;
    assign w_cnt_cur  = (w_cnt_bump && (r_cnt != CNT_MAX)) ? (r_cnt + CNTW'(1)) : r_cnt;

    assign w_hist_new = {cop_mem_error, r_m_wen, r_m_addr, r_m_wdata, cop_mem_rdata, r_m_ben};

    assign vtx_outstanding = r_count;
    assign vtx_proto_err   = r_proto_err;

    // Queue payload write at the tail
    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_q_enc[r_tail]  <= cpu_insn_enc;
            r_q_rs1[r_tail]  <= cpu_rs1;
            r_q_rs2[r_tail]  <= cpu_rs2;
            r_q_cprs[r_tail] <= cprs_snoop;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Protocol monitor: sticky error flag and held-request tracking
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_proto_err <= 1'b0;
            r_held      <= 1'b0;
            r_held_enc  <= '0;
            r_held_rs1  <= '0;
            r_held_rs2  <= '0;
        end else begin
            r_proto_err <= r_proto_err | w_proto_set;
            r_held      <= cpu_insn_req & ~cop_insn_ack;
            r_held_enc  <= cpu_insn_enc;
            r_held_rs1  <= cpu_rs1;
            r_held_rs2  <= cpu_rs2;
        end
    end

    // Pending memory request latch
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_mpend   <= 1'b0;
            r_m_wen   <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_ben   <= '0;
        end else if (w_macc) begin
            r_mpend   <= 1'b1;
            r_m_wen   <= cop_mem_wen;
            r_m_addr  <= cop_mem_addr;
            r_m_wdata <= cop_mem_wdata;
            r_m_ben   <= cop_mem_ben;
        end else if (w_mcomp) begin
            r_mpend   <= 1'b0;
        end else begin
            r_mpend   <= r_mpend;
        end
    end

    // Completed-transaction history, newest at entry 0
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            vtx_mem_hist   <= '0;
            vtx_mem_hvalid <= '0;
        end else if (w_mcomp) begin
            for (int i = MEM_DEPTH - 1; i > 0; i--) begin
                vtx_mem_hist[i*HW +: HW] <= vtx_mem_hist[(i-1)*HW +: HW];
                vtx_mem_hvalid[i]        <= vtx_mem_hvalid[i-1];
            end
            vtx_mem_hist[HW-1:0] <= w_hist_new;
            vtx_mem_hvalid[0]    <= 1'b1;
        end
    end

    // Per-instruction memory counter
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_cur;
        end
    end

    // Retire record: one-cycle valid, fields held until the next retire
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            vtx_valid     <= 1'b0;
            vtx_enc       <= '0;
            vtx_rs1       <= '0;
            vtx_rs2       <= '0;
            vtx_result    <= '0;
            vtx_wen       <= 1'b0;
            vtx_waddr     <= '0;
            vtx_wdata     <= '0;
            vtx_cprs_pre  <= '0;
            vtx_cprs_post <= '0;
            vtx_mem_count <= '0;
        end else begin
            vtx_valid <= w_pop;
            if (w_pop) begin
                vtx_enc       <= r_q_enc[r_head];
                vtx_rs1       <= r_q_rs1[r_head];
                vtx_rs2       <= r_q_rs2[r_head];
                vtx_cprs_pre  <= r_q_cprs[r_head];
                vtx_result    <= cop_result;
                vtx_wen       <= cop_wen;
                vtx_waddr     <= cop_waddr;
                vtx_wdata     <= cop_wdata;
                vtx_cprs_post <= cprs_snoop;
                vtx_mem_count <= w_cnt_cur;
            end
        end
    end

`ifdef FML_RAND_TRACK_EN
    logic [XLEN-1:0] r_rand;
    logic [XLEN-1:0] w_rand_cur;

    assign w_rand_cur = cop_rand_sample ? cop_random : r_rand;

    // Random sample register and its retire-time copy
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_rand   <= '0;
            vtx_rand <= '0;
        end else begin
            r_rand <= w_rand_cur;
            if (w_pop) begin
                vtx_rand <= w_rand_cur;
            end
        end
    end
`else
    logic w_unused_rand;
    assign w_unused_rand = ^{cop_random, cop_rand_sample};
    assign vtx_rand      = '0;
`endif

endmodule
